// File: rtl/reg_scoreboard_decoder.sv
// ---------------------------------------------------------------------------
// reg_scoreboard_decoder
//
// Decodes the writeback select into a registered one-hot register-file write
// enable and keeps a busy scoreboard of destination registers whose writes
// are still in flight. Two read ports are checked against the scoreboard to
// flag RAW hazards. An optional hardwired zero register is never written and
// never marked busy.
//
// Parameters
//   SEL_W     register select width (NUM_REG = 1 << SEL_W)
//   ZERO_REG  index of the hardwired zero register
//   ZERO_EN   1: ZERO_REG is never written / never busy, 0: ordinary register
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               clears the whole scoreboard at the next edge
//   issue_valid/_sel    issuing instruction and its destination
//   issue_ready         issue accepted this cycle (combinational)
//   wb_valid/_sel       writeback this cycle and its destination
//   we_onehot           registered one-hot write enables
//   busy                scoreboard, bit i = write to register i in flight
//   busy_cnt            registered population count, aligned with busy
//   rd_sel_a/_b         read port selects
//   hazard_a/_b         busy bit of the selected read register
//   wb_err              registered pulse: writeback to a non-busy register
// ---------------------------------------------------------------------------
module reg_scoreboard_decoder #(
    parameter int SEL_W    = 5,
    parameter int ZERO_REG = 31,
    parameter int ZERO_EN  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     issue_valid,
    input  logic [SEL_W-1:0]         issue_sel,
    output logic                     issue_ready,
    input  logic                     wb_valid,
    input  logic [SEL_W-1:0]         wb_sel,
    output logic [(1<<SEL_W)-1:0]    we_onehot,
    output logic [(1<<SEL_W)-1:0]    busy,
    output logic [SEL_W:0]           busy_cnt,
    input  logic [SEL_W-1:0]         rd_sel_a,
    input  logic [SEL_W-1:0]         rd_sel_b,
    output logic                     hazard_a,
    output logic                     hazard_b,
    output logic                     wb_err
);

    localparam int              NUM_REG  = 1 << SEL_W;
    localparam logic [SEL_W-1:0] ZERO_SEL = SEL_W'(ZERO_REG);
    localparam bit              ZERO_ON  = (ZERO_EN != 0);

    logic [NUM_REG-1:0] busy_q, busy_d;
    logic [NUM_REG-1:0] we_onehot_q, we_onehot_d;
    logic [SEL_W:0]     busy_cnt_q, busy_cnt_d;
    logic               wb_err_q, wb_err_d;

    logic [NUM_REG-1:0] issue_dec;   // issue_sel decoded
    logic [NUM_REG-1:0] wb_dec;      // wb_sel decoded, qualified by wb_valid
    logic [NUM_REG-1:0] zero_mask;   // constant: bit set for the hardwired zero register
    logic               issue_zero;
    logic               wb_zero;
    logic               issue_fire;

    // Per-register decode: compare each select against the register index.
    generate
        for (genvar gi = 0; gi < NUM_REG; gi++) begin : g_dec
            localparam logic [SEL_W-1:0] IDX     = SEL_W'(gi);
            localparam bit               IS_ZERO = ZERO_ON && (gi == ZERO_REG);
            assign issue_dec[gi] = (issue_sel == IDX);
            assign wb_dec[gi]    = wb_valid && (wb_sel == IDX);
            assign zero_mask[gi] = IS_ZERO;
        end
    endgenerate

    always_comb begin
        issue_zero = ZERO_ON && (issue_sel == ZERO_SEL);
        wb_zero    = ZERO_ON && (wb_sel == ZERO_SEL);

        // A writeback to the same register this cycle frees the slot, so the
        // back-to-back producer can issue without a bubble.
        issue_ready = ~flush & (~busy_q[issue_sel]
                                | (wb_valid & (wb_sel == issue_sel))
                                | issue_zero);
        issue_fire  = issue_valid & issue_ready;

        // Clear on writeback first, then set on issue so that set wins.
        busy_d = busy_q & ~wb_dec;
        if (issue_fire) begin
            busy_d = busy_d | (issue_dec & ~zero_mask);
        end
        if (flush) begin
            busy_d = '0;
        end

        // The write enable is produced even during a flush; only the
        // scoreboard is discarded.
        we_onehot_d = wb_dec & ~zero_mask;
        wb_err_d    = wb_valid & ~busy_q[wb_sel] & ~wb_zero & ~flush;

        busy_cnt_d = '0;
        for (int i = 0; i < NUM_REG; i++) begin
            busy_cnt_d = busy_cnt_d + (SEL_W+1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= '0;
            we_onehot_q <= '0;
            busy_cnt_q  <= '0;
            wb_err_q    <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            we_onehot_q <= we_onehot_d;
            busy_cnt_q  <= busy_cnt_d;
            wb_err_q    <= wb_err_d;
        end
    end

    // No same-cycle writeback forwarding here; the datapath bypass covers it.
    assign hazard_a  = busy_q[rd_sel_a] & ~zero_mask[rd_sel_a];
    assign hazard_b  = busy_q[rd_sel_b] & ~zero_mask[rd_sel_b];

    assign busy      = busy_q;
    assign we_onehot = we_onehot_q;
    assign busy_cnt  = busy_cnt_q;
    assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_reg_scoreboard_decoder.sv
module tb_reg_scoreboard_decoder;

    logic        clk = 1'b0;
    logic        rst_n;

    // Main instance: SEL_W=5, ZERO_REG=31, ZERO_EN=1
    logic        flush, issue_valid, wb_valid;
    logic [4:0]  issue_sel, wb_sel, rd_sel_a, rd_sel_b;
    logic        issue_ready, hazard_a, hazard_b, wb_err;
    logic [31:0] we_onehot, busy;
    logic [5:0]  busy_cnt;

    // Small instance: SEL_W=3, ZERO_REG=7, ZERO_EN=1
    logic        s_flush, s_issue_valid, s_wb_valid;
    logic [2:0]  s_issue_sel, s_wb_sel, s_rd_sel_a, s_rd_sel_b;
    logic        s_issue_ready, s_hazard_a, s_hazard_b, s_wb_err;
    logic [7:0]  s_we_onehot, s_busy;
    logic [3:0]  s_busy_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_scoreboard_decoder #(.SEL_W(5), .ZERO_REG(31), .ZERO_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .issue_valid(issue_valid), .issue_sel(issue_sel), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_sel(wb_sel), .we_onehot(we_onehot),
        .busy(busy), .busy_cnt(busy_cnt),
        .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
        .hazard_a(hazard_a), .hazard_b(hazard_b), .wb_err(wb_err)
    );

    reg_scoreboard_decoder #(.SEL_W(3), .ZERO_REG(7), .ZERO_EN(1)) dut_small (
        .clk(clk), .rst_n(rst_n), .flush(s_flush),
        .issue_valid(s_issue_valid), .issue_sel(s_issue_sel), .issue_ready(s_issue_ready),
        .wb_valid(s_wb_valid), .wb_sel(s_wb_sel), .we_onehot(s_we_onehot),
        .busy(s_busy), .busy_cnt(s_busy_cnt),
        .rd_sel_a(s_rd_sel_a), .rd_sel_b(s_rd_sel_b),
        .hazard_a(s_hazard_a), .hazard_b(s_hazard_b), .wb_err(s_wb_err)
    );

    // Reference model of the main instance: a set of in-flight registers.
    bit          busy_m [32];
    logic [31:0] we_m;
    bit          err_m;
    bit          last_ready, last_haz_a, s_last_ready;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit zh(input int s);
        return s == 31;
    endfunction

    function automatic logic [31:0] busy_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = busy_m[i];
        return v;
    endfunction

    function automatic int busy_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += busy_m[i];
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
        we_m  = '0;
        err_m = 1'b0;
    endtask

    // One cycle on the main instance, starting and ending at a falling edge.
    task automatic step(input bit iv, input int isel, input bit wv, input int wsel,
                        input bit fl, input int ra, input int rb);
        bit exp_ready, fire, nerr;
        logic [31:0] nwe;
        issue_valid = iv; issue_sel = isel[4:0];
        wb_valid    = wv; wb_sel    = wsel[4:0];
        flush       = fl;
        rd_sel_a    = ra[4:0]; rd_sel_b = rb[4:0];
        #1;
        exp_ready = !fl && (!busy_m[isel] || (wv && wsel == isel) || zh(isel));
        chk("issue_ready", issue_ready, exp_ready);
        chk("hazard_a", hazard_a, zh(ra) ? 1'b0 : busy_m[ra]);
        chk("hazard_b", hazard_b, zh(rb) ? 1'b0 : busy_m[rb]);
        last_ready = issue_ready;
        last_haz_a = hazard_a;
        fire = iv && exp_ready;
        nerr = wv && !busy_m[wsel] && !zh(wsel) && !fl;
        nwe  = (wv && !zh(wsel)) ? (32'h1 << wsel) : 32'h0;
        @(posedge clk);
        if (fl) begin
            for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
        end else begin
            if (wv) busy_m[wsel] = 1'b0;
            if (fire && !zh(isel)) busy_m[isel] = 1'b1;
        end
        we_m  = nwe;
        err_m = nerr;
        @(negedge clk);
        chk("busy", busy, busy_vec());
        chk("busy_cnt", busy_cnt, busy_count());
        chk("we_onehot", we_onehot, we_m);
        chk("wb_err", wb_err, err_m);
        $display("step iv=%0d is=%0d wv=%0d ws=%0d fl=%0d busy=%h cnt=%0d we=%h err=%0d",
                 iv, isel, wv, wsel, fl, busy, busy_cnt, we_onehot, wb_err);
    endtask

    task automatic s_cycle(input bit iv, input int isel, input bit wv, input int wsel);
        s_issue_valid = iv; s_issue_sel = isel[2:0];
        s_wb_valid    = wv; s_wb_sel    = wsel[2:0];
        #1;
        s_last_ready = s_issue_ready;
        @(posedge clk);
        @(negedge clk);
        $display("small iv=%0d is=%0d wv=%0d ws=%0d busy=%h cnt=%0d we=%h err=%0d",
                 iv, isel, wv, wsel, s_busy, s_busy_cnt, s_we_onehot, s_wb_err);
    endtask

    function automatic int pick();
        int r = $urandom_range(0, 9);
        if (r == 0) return 31;
        if (r < 8)  return $urandom_range(0, 7);
        return $urandom_range(0, 31);
    endfunction

    task automatic rand_step();
        step($urandom_range(0, 1), pick(), $urandom_range(0, 2) != 0, pick(),
             $urandom_range(0, 15) == 0, pick(), pick());
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 32'h0);
        chk({tag, "_we"}, we_onehot, 32'h0);
        chk({tag, "_cnt"}, busy_cnt, 6'h0);
        chk({tag, "_err"}, wb_err, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        s_flush = 1'b0; s_issue_valid = 1'b0; s_wb_valid = 1'b0;
        s_issue_sel = '0; s_wb_sel = '0; s_rd_sel_a = '0; s_rd_sel_b = '0;
        model_reset();

        // 1: reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            issue_valid = $urandom_range(0, 1); issue_sel = 5'($urandom);
            wb_valid    = $urandom_range(0, 1); wb_sel    = 5'($urandom);
            flush       = $urandom_range(0, 1);
            rd_sel_a    = 5'($urandom); rd_sel_b = 5'($urandom);
            @(negedge clk);
        end
        check_all_zero("reset");
        rst_n = 1'b1;

        // 2: issue X5, writeback three cycles later
        step(1, 5, 0, 0, 0, 5, 0);
        chk("t2_busy5_c1", busy[5], 1'b1);
        chk("t2_cnt_c1", busy_cnt, 6'd1);
        step(0, 0, 0, 0, 0, 5, 0);
        step(0, 0, 0, 0, 0, 5, 0);
        chk("t2_busy5_c3", busy[5], 1'b1);
        step(0, 0, 1, 5, 0, 5, 0);
        chk("t2_we", we_onehot, 32'h0000_0020);
        chk("t2_busy5_after", busy[5], 1'b0);

        // 3: blocked issue, then same-cycle issue + writeback
        step(1, 7, 0, 0, 0, 0, 0);
        step(1, 7, 0, 0, 0, 0, 0);
        chk("t3_ready_blocked", last_ready, 1'b0);
        step(1, 7, 1, 7, 0, 0, 0);
        chk("t3_ready_wb", last_ready, 1'b1);
        chk("t3_busy7", busy[7], 1'b1);
        chk("t3_we", we_onehot, 32'h0000_0080);
        step(0, 0, 1, 7, 0, 0, 0);

        // 4: zero register
        step(1, 31, 1, 31, 0, 31, 31);
        chk("t4_ready", last_ready, 1'b1);
        chk("t4_busy31", busy[31], 1'b0);
        chk("t4_we", we_onehot, 32'h0);
        chk("t4_err", wb_err, 1'b0);

        // 5: flush with a concurrent writeback
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 2, 0, 0, 0, 0, 0);
        step(1, 3, 0, 0, 0, 2, 0);
        chk("t5_busy_set", busy, 32'h0000_000e);
        step(0, 0, 0, 0, 0, 2, 1);
        chk("t5_haz_before", last_haz_a, 1'b1);
        step(1, 4, 1, 2, 1, 2, 3);
        chk("t5_busy", busy, 32'h0);
        chk("t5_cnt", busy_cnt, 6'd0);
        chk("t5_we", we_onehot, 32'h0000_0004);
        chk("t5_err", wb_err, 1'b0);
        step(0, 0, 0, 0, 0, 2, 0);
        chk("t5_haz_after", last_haz_a, 1'b0);

        // 6: writeback to a non-busy register
        step(0, 0, 1, 9, 0, 0, 0);
        chk("t6_err", wb_err, 1'b1);
        chk("t6_we", we_onehot, 32'h0000_0200);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("t6_err_pulse", wb_err, 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 150; i++) rand_step();

        // Asynchronous reset mid-burst
        step(1, 10, 1, 4, 0, 0, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        chk("async_rst_small_busy", s_busy, 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 150; i++) rand_step();

        // Parametric instance; main instance idles from here on
        issue_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;
        s_cycle(0, 0, 1, 5);
        chk("s_err", s_wb_err, 1'b1);
        chk("s_we5", s_we_onehot, 8'h20);
        s_cycle(1, 3, 0, 0);
        chk("s_ready3", s_last_ready, 1'b1);
        chk("s_busy3", s_busy, 8'h08);
        chk("s_cnt1", s_busy_cnt, 4'd1);
        chk("s_err_clr", s_wb_err, 1'b0);
        s_cycle(1, 7, 1, 7);
        chk("s_ready7", s_last_ready, 1'b1);
        chk("s_busy_z", s_busy, 8'h08);
        chk("s_we_z", s_we_onehot, 8'h00);
        chk("s_err_z", s_wb_err, 1'b0);
        s_cycle(1, 3, 0, 0);
        chk("s_ready_blk", s_last_ready, 1'b0);
        s_rd_sel_a = 3'd3;
        #1;
        chk("s_haz3", s_hazard_a, 1'b1);
        s_cycle(0, 0, 1, 3);
        chk("s_we3", s_we_onehot, 8'h08);
        chk("s_busy0", s_busy, 8'h00);
        chk("s_cnt0", s_busy_cnt, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
